fma_result_merge: RTL and testbench

Output end of the FMA special-case path: takes the `spec_mask`/`res_spec` pair that the first-stage special-case handler produces at issue time and carries it in order alongside the multi-cycle normal datapath. When that datapath returns its result for the same operation, the block selects the final IEEE-754 single-precision result. It then applies overflow/underflow substitution, derives per-result class flags and sticky flags, and presents the result through a registered valid/ready output stage. It sits between the FMA normalise/round stage and the VFPU writeback port.

---
 rtl/vfpu_pkg.sv | 37 +++
 rtl/fma_result_merge_if.sv | 44 ++++
 rtl/spec_tag_fifo.sv | 71 +++++++
 rtl/fma_result_merge.sv | 124 ++++++++++++
 tb/tb_fma_result_merge.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/vfpu_pkg.sv
// Shared VFPU definitions: FP32 constants, flag bit layout, special-case tag format.
// Latency: none (types, constants and combinational helper only).
// Backpressure: not applicable.
package vfpu_pkg;

  localparam logic [31:0] FP32_QNAN    = 32'h7fc0_0000;
  localparam logic [7:0]  FP32_EXP_MAX = 8'hff;

  // Result flag vector layout: {nan, inf, zero, ovf, unf}
  localparam int FLG_NAN  = 4;
  localparam int FLG_INF  = 3;
  localparam int FLG_ZERO = 2;
  localparam int FLG_OVF  = 1;
  localparam int FLG_UNF  = 0;
  localparam int NFLAGS   = 5;

  // Issue-time tag carried alongside the normal datapath
  typedef struct packed {
    logic        mask;
    logic [31:0] res_spec;
    logic        nj_mode;
  } spec_tag_t;

  localparam int TAG_W = $bits(spec_tag_t);

  // Classify an FP32 value, returns {nan, inf, zero}
  function automatic logic [2:0] fp32_class(input logic [31:0] x);
    logic exp_max;
    logic exp_zero;
    logic man_zero;
    exp_max  = (x[30:23] == FP32_EXP_MAX);
    exp_zero = (x[30:23] == 8'h00);
    man_zero = (x[22:0] == 23'h0);
    return {exp_max & ~man_zero, exp_max & man_zero, exp_zero & man_zero};
  endfunction

endpackage

// File: rtl/fma_result_merge_if.sv
// Bundle of issue, normal-result and writeback channels of the FMA result merge.
// Latency: none (wiring only).
// Backpressure: valid/ready on every channel; master = environment, slave = merge block.
interface fma_result_merge_if;
  import vfpu_pkg::*;

  logic              iss_valid;
  logic              iss_ready;
  logic              iss_spec_mask;
  logic [31:0]       iss_res_spec;
  logic              iss_nj_mode;

  logic              norm_valid;
  logic              norm_ready;
  logic [31:0]       norm_res;
  logic              norm_ovf;
  logic              norm_unf;

  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_res;
  logic [NFLAGS-1:0] out_flags;
  logic [NFLAGS-1:0] sticky_flags;
  logic              flag_clr;

  modport master (
    output iss_valid, iss_spec_mask, iss_res_spec, iss_nj_mode,
    input  iss_ready,
    output norm_valid, norm_res, norm_ovf, norm_unf,
    input  norm_ready,
    input  out_valid, out_res, out_flags, sticky_flags,
    output out_ready, flag_clr
  );

  modport slave (
    input  iss_valid, iss_spec_mask, iss_res_spec, iss_nj_mode,
    output iss_ready,
    input  norm_valid, norm_res, norm_ovf, norm_unf,
    output norm_ready,
    output out_valid, out_res, out_flags, sticky_flags,
    input  out_ready, flag_clr
  );

endinterface

// File: rtl/spec_tag_fifo.sv
// Synchronous FIFO holding special-case tags in issue order, exposes occupancy count.
// Latency: entry pushed at edge t is visible at the head from cycle t+1.
// Backpressure: push refused when full (even with a same-cycle pop); pop ignored when empty.
module spec_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 34,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_vld,
  output logic [WIDTH-1:0] pop_dat,
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push_vld && (count_q != FULL_CNT);
  assign pop_ok  = pop_vld && (count_q != '0);
  assign pop_dat = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Next-state for storage, pointers and occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  // Control state, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Tag storage, contents only meaningful below count so no reset needed
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/fma_result_merge.sv
// Merges special-case tags with normal FMA results, substitutes ovf/unf, flags and registers the result.
// Latency: pair-pop at edge t presents out_valid after edge t; issue to output is at least 2 edges.
// Backpressure: held output (out_valid & ~out_ready) stalls norm_ready; iss_ready drops at DEPTH tags.
module fma_result_merge
  import vfpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  fma_result_merge_if.slave  bus
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  spec_tag_t         wr_tag;
  spec_tag_t         head_tag;
  logic [TAG_W-1:0]  head_dat;
  logic [AW:0]       fifo_count;
  logic              push;
  logic              adv;
  logic              pair_pop;
  logic              accept;

  logic [31:0]       sel_res;
  logic              sel_ovf;
  logic              sel_unf;
  logic [NFLAGS-1:0] sel_flags;

  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_res_q, out_res_d;
  logic [NFLAGS-1:0] out_flags_q, out_flags_d;
  logic [NFLAGS-1:0] sticky_q, sticky_d;

  assign wr_tag   = '{mask: bus.iss_spec_mask, res_spec: bus.iss_res_spec, nj_mode: bus.iss_nj_mode};
  assign head_tag = spec_tag_t'(head_dat);

  assign bus.iss_ready  = (fifo_count != FULL_CNT);
  assign push           = bus.iss_valid && bus.iss_ready;
  assign adv            = !out_valid_q || bus.out_ready;
  assign bus.norm_ready = (fifo_count != '0) && adv;
  assign pair_pop       = bus.norm_valid && bus.norm_ready;
  assign accept         = out_valid_q && bus.out_ready;

  spec_tag_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (TAG_W)
  ) u_tag_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (push),
    .push_dat (wr_tag),
    .pop_vld  (pair_pop),
    .pop_dat  (head_dat),
    .count    (fifo_count)
  );

  // Pick the final result for the head operation and classify it
  always_comb begin
    sel_res   = bus.norm_res;
    sel_ovf   = 1'b0;
    sel_unf   = 1'b0;
    sel_flags = '0;
    if (head_tag.mask) begin
      // Special-case answer wins; the normal result is consumed but discarded
      sel_res = head_tag.res_spec;
    end else if (bus.norm_ovf) begin
      sel_res = {bus.norm_res[31], FP32_EXP_MAX, 23'h0};
      sel_ovf = 1'b1;
    end else if (bus.norm_unf) begin
      sel_unf = 1'b1;
      if (head_tag.nj_mode) begin
        sel_res = {bus.norm_res[31], 31'h0};
      end
    end
    sel_flags[FLG_NAN:FLG_ZERO] = fp32_class(sel_res);
    sel_flags[FLG_OVF]          = sel_ovf;
    sel_flags[FLG_UNF]          = sel_unf;
  end

  // Output stage loads on pair-pop, drains on acceptance; sticky collects accepted flags
  always_comb begin
    out_valid_d = out_valid_q;
    out_res_d   = out_res_q;
    out_flags_d = out_flags_q;
    sticky_d    = bus.flag_clr ? '0 : sticky_q;
    if (pair_pop) begin
      out_valid_d = 1'b1;
      out_res_d   = sel_res;
      out_flags_d = sel_flags;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    if (accept) begin
      sticky_d = sticky_d | out_flags_q;
    end
  end

  // Output and sticky registers
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
      out_flags_q <= '0;
      sticky_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_res_q   <= out_res_d;
      out_flags_q <= out_flags_d;
      sticky_q    <= sticky_d;
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_res      = out_res_q;
  assign bus.out_flags    = out_flags_q;
  assign bus.sticky_flags = sticky_q;

  // A normal result must never arrive without a matching tag in flight
  norm_without_tag_a : assert property (@(posedge clk) disable iff (rst)
    !(bus.norm_valid && (fifo_count == '0)));

endmodule

// File: tb/tb_fma_result_merge.sv
module tb_fma_result_merge;
  import vfpu_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [31:0] bp_vals [5];

  fma_result_merge_if bus_if ();

  fma_result_merge #(.DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One operation end to end: issue, return normal result, check registered output
  task automatic op(input string tag, input logic m, input logic [31:0] rs, input logic nj,
                    input logic [31:0] nr, input logic ovf, input logic unf,
                    input logic [31:0] er, input logic [4:0] ef);
    bus_if.iss_valid     = 1'b1;
    bus_if.iss_spec_mask = m;
    bus_if.iss_res_spec  = rs;
    bus_if.iss_nj_mode   = nj;
    step();
    bus_if.iss_valid  = 1'b0;
    bus_if.norm_valid = 1'b1;
    bus_if.norm_res   = nr;
    bus_if.norm_ovf   = ovf;
    bus_if.norm_unf   = unf;
    check({tag, "_norm_ready"}, 32'(bus_if.norm_ready), 32'd1);
    step();
    bus_if.norm_valid = 1'b0;
    bus_if.norm_ovf   = 1'b0;
    bus_if.norm_unf   = 1'b0;
    check({tag, "_out_valid"}, 32'(bus_if.out_valid), 32'd1);
    check({tag, "_out_res"}, bus_if.out_res, er);
    check({tag, "_out_flags"}, 32'(bus_if.out_flags), 32'(ef));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bp_vals[0] = 32'h3f80_0000;
    bp_vals[1] = 32'h4000_0000;
    bp_vals[2] = 32'h4040_0000;
    bp_vals[3] = 32'h4080_0000;
    bp_vals[4] = 32'h40a0_0000;

    rst                  = 1'b1;
    bus_if.iss_valid     = 1'b0;
    bus_if.iss_spec_mask = 1'b0;
    bus_if.iss_res_spec  = 32'h0;
    bus_if.iss_nj_mode   = 1'b0;
    bus_if.norm_valid    = 1'b0;
    bus_if.norm_res      = 32'h0;
    bus_if.norm_ovf      = 1'b0;
    bus_if.norm_unf      = 1'b0;
    bus_if.out_ready     = 1'b1;
    bus_if.flag_clr      = 1'b0;

    // Reset state
    step();
    rst = 1'b0;
    check("rst_iss_ready", 32'(bus_if.iss_ready), 32'd1);
    check("rst_norm_ready", 32'(bus_if.norm_ready), 32'd0);
    check("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
    check("rst_sticky", 32'(bus_if.sticky_flags), 32'd0);

    // Special-case NaN; normal result discarded
    op("spec_nan", 1'b1, FP32_QNAN, 1'b0, 32'h3f80_0000, 1'b0, 1'b0, 32'h7fc0_0000, 5'b10000);
    step();
    check("spec_nan_drained", 32'(bus_if.out_valid), 32'd0);
    check("spec_nan_fifo_empty", 32'(bus_if.norm_ready), 32'd0);
    check("sticky_nan", 32'(bus_if.sticky_flags), 32'b10000);

    // Substitution paths
    op("unf_nj", 1'b0, 32'h0, 1'b1, 32'h8000_0123, 1'b0, 1'b1, 32'h8000_0000, 5'b00101);
    op("ovf_pos", 1'b0, 32'h0, 1'b0, 32'h4000_0000, 1'b1, 1'b0, 32'h7f80_0000, 5'b01010);
    op("unf_java", 1'b0, 32'h0, 1'b0, 32'h0000_0123, 1'b0, 1'b1, 32'h0000_0123, 5'b00001);
    op("spec_over_ovf", 1'b1, 32'hff80_0000, 1'b0, 32'h3f80_0000, 1'b1, 1'b0, 32'hff80_0000, 5'b01000);
    op("ovf_neg", 1'b0, 32'h0, 1'b0, 32'hc000_0000, 1'b1, 1'b0, 32'hff80_0000, 5'b01010);
    step();
    check("sticky_all", 32'(bus_if.sticky_flags), 32'b11111);

    // Clear in the same cycle as accepting a zero result
    op("zero_res", 1'b0, 32'h0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 5'b00100);
    bus_if.flag_clr = 1'b1;
    step();
    bus_if.flag_clr = 1'b0;
    check("sticky_clr_accept", 32'(bus_if.sticky_flags), 32'b00100);

    // Backpressure: one output held, four tags queued
    bus_if.out_ready     = 1'b0;
    bus_if.iss_spec_mask = 1'b0;
    bus_if.iss_nj_mode   = 1'b0;
    bus_if.iss_valid     = 1'b1;
    bus_if.iss_res_spec  = 32'h0000_00a0;
    step();
    bus_if.iss_res_spec = 32'h0000_00b0;
    bus_if.norm_valid   = 1'b1;
    bus_if.norm_res     = bp_vals[0];
    step();
    bus_if.iss_res_spec = 32'h0000_00c0;
    bus_if.norm_res     = bp_vals[1];
    check("bp_stall_norm_ready", 32'(bus_if.norm_ready), 32'd0);
    step();
    bus_if.iss_res_spec = 32'h0000_00d0;
    step();
    bus_if.iss_res_spec = 32'h0000_00e0;
    step();
    check("bp_full_iss_ready", 32'(bus_if.iss_ready), 32'd0);
    check("bp_full_out_valid", 32'(bus_if.out_valid), 32'd1);
    check("bp_full_out_res", bus_if.out_res, bp_vals[0]);
    bus_if.iss_res_spec = 32'h0000_00f0;
    step();
    check("bp_hold_out_res", bus_if.out_res, bp_vals[0]);
    check("bp_hold_iss_ready", 32'(bus_if.iss_ready), 32'd0);
    // Release; the extra issue stays refused in the cycle a pop frees space
    bus_if.out_ready = 1'b1;
    step();
    bus_if.iss_valid = 1'b0;
    for (int i = 1; i < 5; i++) begin
      check("bp_order_valid", 32'(bus_if.out_valid), 32'd1);
      check("bp_order_res", bus_if.out_res, bp_vals[i]);
      if (i < 4) begin
        bus_if.norm_res = bp_vals[i+1];
      end else begin
        bus_if.norm_valid = 1'b0;
      end
      if (i == 4) begin
        check("bp_refused_push", 32'(bus_if.norm_ready), 32'd0);
      end
      step();
    end
    check("bp_drained", 32'(bus_if.out_valid), 32'd0);

    // Reset mid-stream with a held output and three tags queued
    bus_if.out_ready    = 1'b0;
    bus_if.iss_valid    = 1'b1;
    bus_if.iss_res_spec = 32'h0;
    step();
    bus_if.norm_valid = 1'b1;
    bus_if.norm_res   = 32'h0000_0000;
    step();
    bus_if.norm_valid = 1'b0;
    step();
    step();
    bus_if.iss_valid = 1'b0;
    check("pre_rst_out_valid", 32'(bus_if.out_valid), 32'd1);
    check("pre_rst_sticky", 32'(bus_if.sticky_flags), 32'b00100);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_out_valid", 32'(bus_if.out_valid), 32'd0);
    check("mid_rst_iss_ready", 32'(bus_if.iss_ready), 32'd1);
    check("mid_rst_sticky", 32'(bus_if.sticky_flags), 32'd0);
    check("mid_rst_empty", 32'(bus_if.norm_ready), 32'd0);
    check("mid_rst_out_res", bus_if.out_res, 32'h0);
    bus_if.out_ready = 1'b1;

    // Function resumes cleanly after reset
    op("post_rst", 1'b1, 32'h7f80_0001, 1'b0, 32'h4000_0000, 1'b0, 1'b0, 32'h7f80_0001, 5'b10000);
    step();
    check("post_rst_empty", 32'(bus_if.norm_ready), 32'd0);
    check("post_rst_sticky", 32'(bus_if.sticky_flags), 32'b10000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
